// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit. It holds the
// opcode constants, the FSM state encoding (also visible on state_dbg),
// the ALU operation encodings and the datapath mux-select constants. It also
// provides a helper that maps an opcode to its immediate format.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Controller states; the numeric value is what state_dbg reports.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
    } state_t;

    // ALU operation encodings driven on alu_control
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Class of ALU work the FSM asks the ALU decoder for
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,  // address / PC arithmetic
        ALUOP_BRANCH = 2'd1,  // comparison selected by branch funct3
        ALUOP_FUNCT  = 2'd2   // R-type or I-type ALU op from funct3/funct7b5
    } alu_op_t;

    // Immediate formats (sel_ext)
    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;
    localparam logic [2:0] EXT_U = 3'b100;

    // Result mux (sel_result)
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Memory address mux (sel_mem_addr)
    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_ALUOUT = 1'b1;

    // ALU source A mux (sel_alu_src_a)
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_AREG  = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    // ALU source B mux (sel_alu_src_b)
    localparam logic [1:0] SRCB_BREG = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    localparam logic [1:0] SRCB_ZERO = 2'd3;

    // Immediate format implied by an opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] ext_sel(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: ext_sel = EXT_I;
            OPC_STORE:                      ext_sel = EXT_S;
            OPC_BRANCH:                     ext_sel = EXT_B;
            OPC_JAL:                        ext_sel = EXT_J;
            OPC_LUI, OPC_AUIPC:             ext_sel = EXT_U;
            default:                        ext_sel = EXT_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the control unit and the multicycle datapath.
//   instr, zero          : datapath -> controller (latched IR, ALU zero flag)
//   sel_*, we_*, alu_*   : controller -> datapath selects and write enables
//   illegal_instr        : controller -> core, unsupported-opcode pulse
//   state_dbg            : controller -> debug, current FSM state
// Modport master is the controller side; modport slave is the datapath side.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;

    logic [31:0] instr;
    logic        zero;
    logic [1:0]  sel_result;
    logic        we_rf;
    logic [2:0]  sel_ext;
    logic [3:0]  alu_control;
    logic        we_ir;
    logic        we_pc;
    logic        we_mem;
    logic        sel_mem_addr;
    logic [1:0]  sel_alu_src_a;
    logic [1:0]  sel_alu_src_b;
    logic        illegal_instr;
    logic [3:0]  state_dbg;

    modport master (
        input  instr, zero,
        output sel_result, we_rf, sel_ext, alu_control, we_ir, we_pc,
               we_mem, sel_mem_addr, sel_alu_src_a, sel_alu_src_b,
               illegal_instr, state_dbg
    );

    modport slave (
        output instr, zero,
        input  sel_result, we_rf, sel_ext, alu_control, we_ir, we_pc,
               we_mem, sel_mem_addr, sel_alu_src_a, sel_alu_src_b,
               illegal_instr, state_dbg
    );

endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational map from the FSM's ALU request class plus instruction fields
// to the ALU operation code.
//   alu_op      : request class (plain add, branch compare, funct-decoded)
//   funct3      : instr[14:12]
//   funct7b5    : instr[30]
//   op5         : instr[5], 1 for R-type, 0 for I-type ALU ops
//   alu_control : ALU operation (package encoding)
// ---------------------------------------------------------------------------
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // NOTE: every variable written in always_comb gets a default first, so
    // no path through the case statements can infer a latch.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;

            // Branches compare through the ALU; the FSM turns the zero flag
            // into a taken decision.
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        alu_control = ALU_SUB;
                endcase
            end

            ALUOP_FUNCT: begin
                case (funct3)
                    // instr[30] is an immediate bit for ADDI, so SUB needs R-type.
                    3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    // Shifts carry funct7b5 in both R and I forms (SRA/SRAI).
                    3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end

            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Main control unit of the multicycle RV32I core. A Moore FSM sequences each
// instruction through 3-5 cycles and drives every datapath select and write
// enable. The branch PC write is Mealy, depending on the live zero flag.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset; while low all enables and selects
//          are forced to 0 and alu_control to ADD
//   ctrl : multicycle_controller_if.master (instr/zero in, controls out)
// ---------------------------------------------------------------------------
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
)
(
    input logic                      clk,
    input logic                      rst,
    multicycle_controller_if.master  ctrl
);

    state_t     state_q;
    state_t     state_d;
    alu_op_t    alu_op;
    logic       taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;

    assign opcode   = ctrl.instr[6:0];
    assign funct3   = ctrl.instr[14:12];
    assign funct7b5 = ctrl.instr[30];

    // Register fields and the upper immediate bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{ctrl.instr[31], ctrl.instr[29:15], ctrl.instr[11:7]};

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; the reset is synchronous and only seen on an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch decision from the comparison the ALU is doing this cycle.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken =  ctrl.zero;  // beq  (SUB)
            3'b001:  taken = !ctrl.zero;  // bne  (SUB)
            3'b100:  taken = !ctrl.zero;  // blt  (SLT)
            3'b101:  taken =  ctrl.zero;  // bge  (SLT)
            3'b110:  taken = !ctrl.zero;  // bltu (SLTU)
            3'b111:  taken =  ctrl.zero;  // bgeu (SLTU)
            default: taken = 1'b0;        // 010/011 are not branches
        endcase
    end

    always_comb begin
        state_d            = state_q;
        alu_op             = ALUOP_ADD;
        ctrl.sel_result    = RES_ALUOUT;
        ctrl.we_rf         = 1'b0;
        ctrl.we_ir         = 1'b0;
        ctrl.we_pc         = 1'b0;
        ctrl.we_mem        = 1'b0;
        ctrl.sel_mem_addr  = ADDR_PC;
        ctrl.sel_alu_src_a = SRCA_PC;
        ctrl.sel_alu_src_b = SRCB_BREG;
        ctrl.illegal_instr = 1'b0;
        ctrl.sel_ext       = ext_sel(opcode);

        case (state_q)
            S_FETCH: begin
                ctrl.sel_mem_addr  = ADDR_PC;
                ctrl.we_ir         = 1'b1;
                ctrl.sel_alu_src_a = SRCA_PC;
                ctrl.sel_alu_src_b = SRCB_FOUR;
                ctrl.sel_result    = RES_ALU;
                ctrl.we_pc         = 1'b1;
                state_d            = S_DECODE;
            end

            // Precompute oldPC+imm into ALUOut for branches and jal.
            S_DECODE: begin
                ctrl.sel_alu_src_a = SRCA_OLDPC;
                ctrl.sel_alu_src_b = SRCB_IMM;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_OP:              state_d = S_EXECR;
                    OPC_OP_IMM:          state_d = S_EXECI;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_JALR:            state_d = S_JALR1;
                    OPC_LUI:             state_d = S_LUI;
                    OPC_AUIPC:           state_d = S_AUIPC;
                    OPC_FENCE:           state_d = S_FETCH;
                    default: begin
                        ctrl.illegal_instr = 1'b1;
                        state_d            = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                ctrl.sel_alu_src_a = SRCA_AREG;
                ctrl.sel_alu_src_b = SRCB_IMM;
                // Only loads and stores reach here; opcode[5] tells them apart.
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                ctrl.sel_mem_addr = ADDR_ALUOUT;
                state_d           = S_MEMWB;
            end

            S_MEMWB: begin
                ctrl.sel_result = RES_DATA;
                ctrl.we_rf      = 1'b1;
                state_d         = S_FETCH;
            end

            S_MEMWRITE: begin
                ctrl.sel_mem_addr = ADDR_ALUOUT;
                ctrl.we_mem       = 1'b1;
                state_d           = S_FETCH;
            end

            S_EXECR: begin
                ctrl.sel_alu_src_a = SRCA_AREG;
                ctrl.sel_alu_src_b = SRCB_BREG;
                alu_op             = ALUOP_FUNCT;
                state_d            = S_ALUWB;
            end

            S_EXECI: begin
                ctrl.sel_alu_src_a = SRCA_AREG;
                ctrl.sel_alu_src_b = SRCB_IMM;
                alu_op             = ALUOP_FUNCT;
                state_d            = S_ALUWB;
            end

            S_ALUWB: begin
                ctrl.sel_result = RES_ALUOUT;
                ctrl.we_rf      = 1'b1;
                state_d         = S_FETCH;
            end

            // ALUOut still holds the target computed in DECODE.
            S_BRANCH: begin
                ctrl.sel_alu_src_a = SRCA_AREG;
                ctrl.sel_alu_src_b = SRCB_BREG;
                alu_op             = ALUOP_BRANCH;
                ctrl.sel_result    = RES_ALUOUT;
                ctrl.we_pc         = taken;
                state_d            = S_FETCH;
            end

            // PC <- target from ALUOut while the ALU forms the link value.
            S_JAL: begin
                ctrl.sel_result    = RES_ALUOUT;
                ctrl.we_pc         = 1'b1;
                ctrl.sel_alu_src_a = SRCA_OLDPC;
                ctrl.sel_alu_src_b = SRCB_FOUR;
                state_d            = S_ALUWB;
            end

            S_JALR1: begin
                ctrl.sel_alu_src_a = SRCA_AREG;
                ctrl.sel_alu_src_b = SRCB_IMM;
                state_d            = S_JALR2;
            end

            // Target bit 0 is passed through unchanged.
            S_JALR2: begin
                ctrl.sel_result    = RES_ALUOUT;
                ctrl.we_pc         = 1'b1;
                ctrl.sel_alu_src_a = SRCA_OLDPC;
                ctrl.sel_alu_src_b = SRCB_FOUR;
                state_d            = S_ALUWB;
            end

            S_LUI: begin
                ctrl.sel_alu_src_a = SRCA_ZERO;
                ctrl.sel_alu_src_b = SRCB_IMM;
                state_d            = S_ALUWB;
            end

            S_AUIPC: begin
                ctrl.sel_alu_src_a = SRCA_OLDPC;
                ctrl.sel_alu_src_b = SRCB_IMM;
                state_d            = S_ALUWB;
            end

            default: state_d = S_FETCH;
        endcase

        // Reset wins over any state so a write cannot leak out in the cycle
        // the reset is sampled.
        if (!rst) begin
            alu_op             = ALUOP_ADD;
            ctrl.sel_result    = RES_ALUOUT;
            ctrl.we_rf         = 1'b0;
            ctrl.we_ir         = 1'b0;
            ctrl.we_pc         = 1'b0;
            ctrl.we_mem        = 1'b0;
            ctrl.sel_mem_addr  = ADDR_PC;
            ctrl.sel_alu_src_a = SRCA_PC;
            ctrl.sel_alu_src_b = SRCB_BREG;
            ctrl.illegal_instr = 1'b0;
            ctrl.sel_ext       = EXT_I;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (ctrl.alu_control)
    );

    assign ctrl.state_dbg = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I core. It sits directly upstream of the multicycle datapath and decodes the latched instruction word and ALU zero flag. A Moore FSM, plus a little Mealy logic for the branch decision, drives every select and write-enable on the datapath and the memory write strobe. Each instruction takes 3–5 cycles.

Parameters:
- RESET_STATE, FETCH: state entered on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- instr  in  32  latched instruction register (opcode [6:0], funct3 [14:12], funct7b5 [30])
- zero  in  1  ALU zero flag, combinational this cycle
- sel_result  out  2  0=ALUOut reg, 1=data reg, 2=live ALU result
- we_rf  out  1  register-file write enable
- sel_ext  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
- alu_control  out  4  ALU operation (package encoding)
- we_ir  out  1  instruction-register / old-PC load
- we_pc  out  1  PC load
- we_mem  out  1  data-memory write strobe
- sel_mem_addr  out  1  0=PC, 1=ALUOut
- sel_alu_src_a  out  2  0=PC, 1=oldPC, 2=A reg, 3=zero
- sel_alu_src_b  out  2  0=B reg, 1=imm, 2=const 4, 3=zero
- illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: sampled on the clock edge while rst=0, the state becomes FETCH. While rst=0, the outputs are forced to:
  - we_pc=we_ir=we_rf=we_mem=0, illegal_instr=0
  - all selects=0, alu_control=ADD
- Reset overrides any state, including mid-instruction; no partial write may issue in the reset cycle.
- sel_ext is combinational from the opcode in every state:
  - load/op-imm/jalr → I
  - store → S
  - branch → B
  - jal → J
  - lui/auipc → U
  - otherwise → I
- Unlisted outputs are 0 in every state.
- State actions and transitions:
  - FETCH: addr=PC; we_ir=1; A=PC, B=4, ADD; sel_result=2; we_pc=1 → DECODE.
  - DECODE: A=oldPC, B=imm, ADD (precomputes branch/jal target into ALUOut). Next state by opcode:
    - load/store → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - branch → BRANCH
    - jal → JAL
    - jalr → JALR1
    - lui → LUI
    - auipc → AUIPC
    - fence → FETCH
    - else: illegal_instr=1 → FETCH
  - MEMADR: A=Areg, B=imm, ADD → MEMREAD if load, MEMWRITE if store.
  - MEMREAD: sel_mem_addr=1 → MEMWB.
  - MEMWB: sel_result=1, we_rf=1 → FETCH.
  - MEMWRITE: sel_mem_addr=1, we_mem=1 → FETCH.
  - EXECR: A=Areg, B=Breg, ALU from funct3/funct7b5 → ALUWB.
  - EXECI: A=Areg, B=imm, ALU from funct3; funct7b5 is honoured only for shifts (SRAI) → ALUWB.
  - ALUWB: sel_result=0, we_rf=1 → FETCH.
  - BRANCH: A=Areg, B=Breg; sel_result=0; we_pc=taken → FETCH. ALU op and taken condition by funct3:
    - beq: SUB, taken=zero
    - bne: SUB, taken=!zero
    - blt: SLT, taken=!zero
    - bge: SLT, taken=zero
    - bltu: SLTU, taken=!zero
    - bgeu: SLTU, taken=zero
    - funct3 010/011: never taken
  - JAL: sel_result=0, we_pc=1 (PC←target); A=oldPC, B=4, ADD → ALUWB (rd←oldPC+4).
  - JALR1: A=Areg, B=imm, ADD → JALR2.
  - JALR2: sel_result=0, we_pc=1; A=oldPC, B=4, ADD → ALUWB. Target bit 0 is not cleared.
  - LUI: A=zero, B=imm, ADD → ALUWB.
  - AUIPC: A=oldPC, B=imm, ADD → ALUWB.
- A write to rd=x0 is still issued; the register file ignores it.
- CPI:
  - load 5
  - store, R, I, jal, lui, auipc 4
  - jalr 5
  - branch 3

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - state enum (4-bit)
  - ALU encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001
  - sel_ext and mux-select constants
- One sub-module, alu_decoder: combinational map of (alu_op class, funct3, funct7b5, opcode[5]) → alu_control.

Test Plan:
- Reset: hold rst=0 for 2 cycles while forcing instr=lw → all enables 0, state_dbg=FETCH. Release → FETCH asserts we_ir=1, we_pc=1, sel_alu_src_b=2.
- lw x5,8(x1) (0x0080A283): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. Check sel_mem_addr=1 in MEMREAD; sel_result=1, we_rf=1 in MEMWB; 5 cycles.
- sw, then sub x3,x1,x2 (0x402081B3): sw gives we_mem=1 only in MEMWRITE. sub gives EXECR alu_control=0001, then ALUWB we_rf=1.
- beq (funct3=000) with zero=1 → BRANCH we_pc=1. Repeat with zero=0 → we_pc=0. bge with zero=1 → we_pc=1.
- jal x1,+16 → JAL we_pc=1, sel_result=0, then ALUWB we_rf=1. jalr → JALR1, JALR2(we_pc=1), ALUWB.
- Opcode 0x7F → illegal_instr pulse in DECODE, next state FETCH. Also pull rst=0 during MEMWRITE → we_mem=0 that cycle, then FETCH.
